layer_mixer: RTL and testbench

Parametrised pixel compositor for the VGA path. It takes NUM_LAYERS layer generators, each with a request flag and an RGB value, and selects or blends them per pixel. A frame-synchronous fade engine scales the result. The block is registered and outputs aligned pixel coordinates, so the downstream DAC/VGA driver sees colour and position from the same pixel.

---
 rtl/layer_mixer_if.sv | 32 +++
 rtl/layer_mixer.sv | 202 ++++++++++++++++++++
 tb/tb_layer_mixer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_mixer_if.sv
// Pixel-side bus of the layer mixer: layer requests and colours in, composited
// pixel, aligned coordinates and fade status out.
interface layer_mixer_if #(
    parameter int NUM_LAYERS = 5,
    parameter int COLOR_W    = 8
);
    logic [9:0]                      x_pos;
    logic [9:0]                      y_pos;
    logic [NUM_LAYERS-1:0]           req;
    logic [NUM_LAYERS*3*COLOR_W-1:0] rgb_in;
    logic [NUM_LAYERS-1:0]           layer_en;
    logic                            blend_mode;
    logic                            frame_start;
    logic                            fade_start;
    logic [COLOR_W-1:0]              red;
    logic [COLOR_W-1:0]              green;
    logic [COLOR_W-1:0]              blue;
    logic [9:0]                      x_out;
    logic [9:0]                      y_out;
    logic                            fade_busy;
    logic                            fade_done;

    modport master (
        output x_pos, y_pos, req, rgb_in, layer_en, blend_mode, frame_start, fade_start,
        input  red, green, blue, x_out, y_out, fade_busy, fade_done
    );

    modport slave (
        input  x_pos, y_pos, req, rgb_in, layer_en, blend_mode, frame_start, fade_start,
        output red, green, blue, x_out, y_out, fade_busy, fade_done
    );
endinterface

// File: rtl/layer_mixer.sv
// Two-stage VGA layer compositor: priority select or top-two average in stage 1,
// frame-synchronous fade scaling in stage 2, with coordinates carried alongside.
module layer_mixer #(
    parameter int                     NUM_LAYERS = 5,
    parameter int                     COLOR_W    = 8,
    parameter int                     FADE_STEP  = 16,
    parameter logic [3*COLOR_W-1:0]   BG_COLOR   = 24'h000000
) (
    input  logic         clk,
    input  logic         rst,
    layer_mixer_if.slave bus
);
    localparam int         PIX_W = 3 * COLOR_W;
    localparam int         IDX_W = $clog2(NUM_LAYERS);
    localparam logic [7:0] STEP8 = 8'(FADE_STEP);
    localparam logic [8:0] STEP9 = 9'(FADE_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FADE_OUT,
        S_BLACK,
        S_FADE_IN
    } fade_state_t;

    logic [NUM_LAYERS-1:0] w_eff;
    logic [PIX_W-1:0]      w_layer [NUM_LAYERS];
    logic [IDX_W-1:0]      w_top_idx;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_top_vld;
    logic                  w_next_vld;
    logic [PIX_W-1:0]      w_top_pix;
    logic [PIX_W-1:0]      w_next_pix;
    logic [COLOR_W:0]      w_sum [3];
    logic [PIX_W-1:0]      w_avg_pix;
    logic [PIX_W-1:0]      w_sel_pix;

    logic [PIX_W-1:0]      r_s1_pix;
    logic [9:0]            r_s1_x;
    logic [9:0]            r_s1_y;
    logic [7:0]            r_s1_level;
    logic [PIX_W-1:0]      r_out_pix;
    logic [9:0]            r_out_x;
    logic [9:0]            r_out_y;

    logic [8:0]            w_lvl_p1;
    logic [COLOR_W+8:0]    w_prod [3];
    logic [PIX_W-1:0]      w_scaled;

    fade_state_t           r_state;
    fade_state_t           w_state_nxt;
    logic [7:0]            r_level;
    logic [7:0]            w_level_nxt;
    logic [8:0]            w_inc;
    logic                  r_fade_done;
    logic                  w_done_nxt;
    logic                  w_fade_busy;

    assign w_eff = bus.req & bus.layer_en;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_layer[i] = bus.rgb_in[i*PIX_W +: PIX_W];
        end
    end

    // Ascending scan: each newly found requester becomes the top, the old top drops to next.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        w_top_idx  = '0;
        w_next_idx = '0;
        w_top_vld  = 1'b0;
        w_next_vld = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (w_eff[i]) begin
                w_next_idx = w_top_idx;
                w_next_vld = w_top_vld;
                w_top_idx  = IDX_W'(i);
                w_top_vld  = 1'b1;
            end
        end
    end

    assign w_top_pix  = w_layer[w_top_idx];
    assign w_next_pix = w_layer[w_next_idx];

    always_comb begin
        w_avg_pix = '0;
        for (int c = 0; c < 3; c++) begin
            w_sum[c] = {1'b0, w_top_pix[c*COLOR_W +: COLOR_W]}
                     + {1'b0, w_next_pix[c*COLOR_W +: COLOR_W]};
            w_avg_pix[c*COLOR_W +: COLOR_W] = w_sum[c][COLOR_W:1];
        end
    end

    always_comb begin
        w_sel_pix = w_top_pix;
        if (!w_top_vld) begin
            w_sel_pix = BG_COLOR;
        end else if (bus.blend_mode && w_next_vld) begin
            w_sel_pix = w_avg_pix;
        end
    end

    // Level+1 makes 255 an exact pass-through and 0 fully black.
    always_comb begin
        w_scaled = '0;
        w_lvl_p1 = {1'b0, r_s1_level} + 9'd1;
        for (int c = 0; c < 3; c++) begin
            w_prod[c] = (COLOR_W+9)'(r_s1_pix[c*COLOR_W +: COLOR_W]) * (COLOR_W+9)'(w_lvl_p1);
            w_scaled[c*COLOR_W +: COLOR_W] = w_prod[c][COLOR_W+7:8];
        end
    end

    // The level travels with the pixel so a frame_start edge only affects later pixels.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so each stage samples the previous stage's pre-edge value.
        if (rst) begin
            r_s1_pix   <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_level <= 8'hFF;
            r_out_pix  <= '0;
            r_out_x    <= '0;
            r_out_y    <= '0;
        end else begin
            r_s1_pix   <= w_sel_pix;
            r_s1_x     <= bus.x_pos;
            r_s1_y     <= bus.y_pos;
            r_s1_level <= r_level;
            r_out_pix  <= w_scaled;
            r_out_x    <= r_s1_x;
            r_out_y    <= r_s1_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_level     <= 8'hFF;
            r_fade_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_fade_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_done_nxt  = 1'b0;
        w_inc       = {1'b0, r_level} + STEP9;
        case (r_state)
            S_IDLE: begin
                w_level_nxt = 8'hFF;
                if (bus.fade_start) w_state_nxt = S_FADE_OUT;
            end
            S_FADE_OUT: begin
                if (bus.frame_start) begin
                    if (r_level <= STEP8) begin
                        w_level_nxt = '0;
                        w_state_nxt = S_BLACK;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_level_nxt = r_level - STEP8;
                    end
                end
            end
            S_BLACK: begin
                w_level_nxt = '0;
                if (bus.fade_start) w_state_nxt = S_FADE_IN;
            end
            S_FADE_IN: begin
                if (bus.frame_start) begin
                    if (w_inc >= 9'd255) begin
                        w_level_nxt = 8'hFF;
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_level_nxt = w_inc[7:0];
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_level_nxt = 8'hFF;
            end
        endcase
    end

    always_comb begin
        w_fade_busy = (r_state == S_FADE_OUT) || (r_state == S_FADE_IN);
    end

    assign bus.red       = r_out_pix[3*COLOR_W-1 -: COLOR_W];
    assign bus.green     = r_out_pix[2*COLOR_W-1 -: COLOR_W];
    assign bus.blue      = r_out_pix[COLOR_W-1:0];
    assign bus.x_out     = r_out_x;
    assign bus.y_out     = r_out_y;
    assign bus.fade_busy = w_fade_busy;
    assign bus.fade_done = r_fade_done;
endmodule

// File: tb/tb_layer_mixer.sv
// Self-checking bench for layer_mixer: directed compositing and fade scenarios,
// then randomized traffic, all compared against a behavioural reference model.
module tb_layer_mixer;
    localparam int          NL   = 5;
    localparam int          CW   = 8;
    localparam int          STEP = 64;
    localparam logic [23:0] BG   = 24'h000000;

    typedef struct {
        logic [23:0] rgb;
        logic [9:0]  x;
        logic [9:0]  y;
    } pix_t;

    logic clk = 1'b0;
    logic rst;

    layer_mixer_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

    layer_mixer #(
        .NUM_LAYERS (NL),
        .COLOR_W    (CW),
        .FADE_STEP  (STEP),
        .BG_COLOR   (BG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   m_level  = 255;
    int   m_phase  = 0;
    bit   m_done   = 1'b0;
    pix_t pipe0    = '{24'h0, 10'h0, 10'h0};
    pix_t pipe1    = '{24'h0, 10'h0, 10'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] out_rgb();
        return 32'({bus.red, bus.green, bus.blue});
    endfunction

    // Reference compositor: top-down scan of enabled requesters, plain integer average.
    function automatic logic [23:0] model_pix();
        int          top = -1;
        int          nxt = -1;
        logic [23:0] a;
        logic [23:0] b;
        logic [23:0] r;
        for (int i = NL - 1; i >= 0; i--) begin
            if (bus.req[i] && bus.layer_en[i]) begin
                if (top < 0) top = i;
                else if (nxt < 0) nxt = i;
            end
        end
        if (top < 0) return BG;
        a = bus.rgb_in[top*24 +: 24];
        if (!bus.blend_mode || nxt < 0) return a;
        b = bus.rgb_in[nxt*24 +: 24];
        for (int c = 0; c < 3; c++) begin
            r[c*8 +: 8] = 8'((int'(a[c*8 +: 8]) + int'(b[c*8 +: 8])) / 2);
        end
        return r;
    endfunction

    function automatic logic [23:0] model_scale(input logic [23:0] p, input int lvl);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            r[c*8 +: 8] = 8'((int'(p[c*8 +: 8]) * (lvl + 1)) / 256);
        end
        return r;
    endfunction

    // One clock: predict from the current inputs, advance the fade model, check outputs.
    task automatic cycle();
        pix_t e;
        bit   was_rst;
        was_rst = rst;
        e.rgb = model_scale(model_pix(), m_level);
        e.x   = bus.x_pos;
        e.y   = bus.y_pos;
        if (was_rst) begin
            m_phase = 0;
            m_level = 255;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: if (bus.fade_start) m_phase = 1;
                1: if (bus.frame_start) begin
                    m_level = (m_level > STEP) ? m_level - STEP : 0;
                    if (m_level == 0) begin
                        m_phase = 2;
                        m_done  = 1'b1;
                    end
                end
                2: if (bus.fade_start) m_phase = 3;
                default: if (bus.frame_start) begin
                    m_level = (m_level + STEP > 255) ? 255 : m_level + STEP;
                    if (m_level == 255) begin
                        m_phase = 0;
                        m_done  = 1'b1;
                    end
                end
            endcase
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            pipe0 = '{24'h0, 10'h0, 10'h0};
            pipe1 = '{24'h0, 10'h0, 10'h0};
        end else begin
            pipe1 = pipe0;
            pipe0 = e;
        end
        if (bus.fade_done === 1'b1) n_done++;
        check("rgb", out_rgb(), 32'(pipe1.rgb));
        check("x_out", 32'(bus.x_out), 32'(pipe1.x));
        check("y_out", 32'(bus.y_out), 32'(pipe1.y));
        check("fade_busy", 32'(bus.fade_busy), 32'(m_phase == 1 || m_phase == 3));
        check("fade_done", 32'(bus.fade_done), 32'(m_done));
    endtask

    task automatic frame_then_idle(input int idle, input bit fade_in_gap);
        bus.frame_start = 1'b1;
        cycle();
        bus.frame_start = 1'b0;
        for (int i = 0; i < idle; i++) begin
            bus.fade_start = fade_in_gap && (i == 0);
            cycle();
        end
        bus.fade_start = 1'b0;
    endtask

    task automatic set_layer(input int idx, input logic [23:0] col);
        bus.rgb_in[idx*24 +: 24] = col;
    endtask

    initial begin
        logic [7:0] out_tbl [4];
        logic [7:0] in_tbl  [4];
        int         done0;
        out_tbl = '{8'h60, 8'h40, 8'h20, 8'h00};
        in_tbl  = '{8'h20, 8'h40, 8'h60, 8'h80};

        rst             = 1'b1;
        bus.x_pos       = '0;
        bus.y_pos       = '0;
        bus.req         = '0;
        bus.rgb_in      = '0;
        bus.layer_en    = '0;
        bus.blend_mode  = 1'b0;
        bus.frame_start = 1'b0;
        bus.fade_start  = 1'b0;
        cycle();
        cycle();
        check("reset_rgb", out_rgb(), 32'h0);
        check("reset_busy", 32'(bus.fade_busy), 32'h0);
        rst = 1'b0;

        // Priority select with aligned coordinates
        set_layer(0, 24'h0A0B0C);
        set_layer(1, 24'h102030);
        set_layer(2, 24'hA0B0C0);
        bus.req      = 5'b00111;
        bus.layer_en = 5'b11111;
        bus.x_pos    = 10'd123;
        bus.y_pos    = 10'd45;
        cycle();
        bus.x_pos = 10'd124;
        cycle();
        check("prio_rgb", out_rgb(), 32'h00A0B0C0);
        check("prio_x", 32'(bus.x_out), 32'd123);
        check("prio_y", 32'(bus.y_out), 32'd45);

        // Mask hides the only requester, then re-enables it
        bus.req      = 5'b00100;
        bus.layer_en = 5'b11011;
        cycle();
        cycle();
        check("mask_bg", out_rgb(), 32'(BG));
        bus.layer_en = 5'b11111;
        cycle();
        cycle();
        check("mask_on", out_rgb(), 32'h00A0B0C0);

        // Blend of top two, then a single requester passes through
        set_layer(4, 24'hFF0000);
        set_layer(3, 24'h0000FF);
        bus.req        = 5'b11000;
        bus.blend_mode = 1'b1;
        cycle();
        cycle();
        check("blend_avg", out_rgb(), 32'h007F007F);
        set_layer(1, 24'h123456);
        bus.req = 5'b00010;
        cycle();
        cycle();
        check("blend_single", out_rgb(), 32'h00123456);

        // Fade out on a constant grey, with an ignored fade_start mid-fade
        bus.blend_mode = 1'b0;
        set_layer(0, 24'h808080);
        bus.req = 5'b00001;
        cycle();
        cycle();
        check("fade_pre", 32'(bus.red), 32'h80);
        bus.fade_start = 1'b1;
        cycle();
        bus.fade_start = 1'b0;
        cycle();
        done0 = n_done;
        for (int k = 0; k < 4; k++) begin
            frame_then_idle(3, k == 1);
            check("fade_out_red", 32'(bus.red), 32'(out_tbl[k]));
        end
        check("fade_out_done_cnt", 32'(n_done - done0), 32'd1);
        check("black_busy", 32'(bus.fade_busy), 32'h0);

        // Fade back in
        bus.fade_start = 1'b1;
        cycle();
        bus.fade_start = 1'b0;
        done0 = n_done;
        for (int k = 0; k < 4; k++) begin
            frame_then_idle(3, 1'b0);
            check("fade_in_red", 32'(bus.red), 32'(in_tbl[k]));
        end
        check("fade_in_done_cnt", 32'(n_done - done0), 32'd1);

        // Simultaneous fade_start and frame_start from IDLE: no step yet
        bus.fade_start = 1'b1;
        frame_then_idle(3, 1'b0);
        check("simul_red", 32'(bus.red), 32'h80);
        check("simul_busy", 32'(bus.fade_busy), 32'h1);
        frame_then_idle(3, 1'b0);
        check("simul_step1", 32'(bus.red), 32'h60);
        frame_then_idle(3, 1'b0);
        check("simul_step2", 32'(bus.red), 32'h40);

        // Reset at level 127: busy drops, two zero pixels, then unscaled
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_busy", 32'(bus.fade_busy), 32'h0);
        check("rst_out0", 32'(bus.red), 32'h00);
        cycle();
        check("rst_out1", 32'(bus.red), 32'h00);
        cycle();
        check("rst_out2", 32'(bus.red), 32'h80);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NL; i++) set_layer(i, 24'($urandom));
            bus.req         = 5'($urandom);
            bus.layer_en    = 5'($urandom | $urandom);
            bus.blend_mode  = 1'($urandom);
            bus.x_pos       = 10'($urandom);
            bus.y_pos       = 10'($urandom);
            bus.frame_start = ($urandom_range(0, 11) == 0);
            bus.fade_start  = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
